// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Two-port (CPU / DMA) arbiter in front of a single-port data
//             memory. The grant is combinational, with a fixed CPU priority
//             and an anti-starvation override for DMA. It tracks which port
//             owns the read that is in flight, routes the one-cycle-latency
//             read data back to that port, and keeps saturating performance
//             counters.
//  Ports    : clk, reset (sync, active-low)
//             cpu_*  : req/we/addr/wdata in, gnt/rvalid/rdata out
//             dma_*  : req/we/addr/wdata in, gnt/rvalid/rdata out
//             mem_*  : en/we/addr/wdata out, rdata in
//             cpu_gnt_count / dma_gnt_count / conflict_count : 32-bit counters
//  Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int AW       = 32
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [31:0]   cpu_rdata,

  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [31:0]   dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [31:0]   dma_rdata,

  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,

  output logic [31:0]   cpu_gnt_count,
  output logic [31:0]   dma_gnt_count,
  output logic [31:0]   conflict_count
);

  // The wait counter must be able to hold MAX_WAIT itself; keep at least one
  // bit so a MAX_WAIT of 0 (DMA always wins conflicts) still elaborates.
  localparam int            WW       = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
  localparam logic [31:0]   CNT_MAX  = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  logic [WW-1:0] dma_wait_q, dma_wait_d;
  owner_t        owner_q,    owner_d;
  logic [31:0]   cpu_cnt_q,  cpu_cnt_d;
  logic [31:0]   dma_cnt_q,  dma_cnt_d;
  logic [31:0]   cfl_cnt_q,  cfl_cnt_d;

  logic          dma_force;
  logic          conflict;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != CNT_MAX)) ? v + 32'd1 : v;
  endfunction

  // --------------------------------------------------------------------------
  // Grant and memory mux
  // --------------------------------------------------------------------------
  always_comb begin
    dma_force = (dma_wait_q == WAIT_MAX);
    conflict  = cpu_req & dma_req;

    // CPU wins unless DMA has already lost MAX_WAIT conflicts in a row.
    // Reset gates the grants so that no access leaks out while reset is held.
    cpu_gnt = reset & cpu_req & ~(dma_req & dma_force);
    dma_gnt = reset & dma_req & ~cpu_gnt;

    mem_en    = cpu_gnt | dma_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_gnt) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Read return: the owner register selects which port sees mem_rdata. It is
  // also gated by reset, so a read granted just before reset never completes.
  // --------------------------------------------------------------------------
  always_comb begin
    cpu_rvalid = reset & (owner_q == OWN_CPU);
    dma_rvalid = reset & (owner_q == OWN_DMA);
    cpu_rdata  = cpu_rvalid ? mem_rdata : 32'd0;
    dma_rdata  = dma_rvalid ? mem_rdata : 32'd0;
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    dma_wait_d = dma_wait_q;
    if (dma_gnt) begin
      dma_wait_d = '0;
    end else if (dma_req && (dma_wait_q != WAIT_MAX)) begin
      dma_wait_d = dma_wait_q + WW'(1);
    end

    owner_d = OWN_NONE;
    if (cpu_gnt && !cpu_we) begin
      owner_d = OWN_CPU;
    end else if (dma_gnt && !dma_we) begin
      owner_d = OWN_DMA;
    end

    cpu_cnt_d = sat_inc(cpu_cnt_q, cpu_gnt);
    dma_cnt_d = sat_inc(dma_cnt_q, dma_gnt);
    cfl_cnt_d = sat_inc(cfl_cnt_q, conflict);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dma_wait_q <= '0;
      owner_q    <= OWN_NONE;
      cpu_cnt_q  <= '0;
      dma_cnt_q  <= '0;
      cfl_cnt_q  <= '0;
    end else begin
      dma_wait_q <= dma_wait_d;
      owner_q    <= owner_d;
      cpu_cnt_q  <= cpu_cnt_d;
      dma_cnt_q  <= dma_cnt_d;
      cfl_cnt_q  <= cfl_cnt_d;
    end
  end

  assign cpu_gnt_count  = cpu_cnt_q;
  assign dma_gnt_count  = dma_cnt_q;
  assign conflict_count = cfl_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Purpose  : Self-checking bench for dmem_arbiter. A behavioural model
//             (loss counter, pending-read owner, saturating counts) is
//             compared against every output on every cycle. Directed
//             sequences with literal expectations pin the model, followed by
//             randomized traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int MAX_WAIT = 4;
  localparam int AW       = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr;
  logic [31:0]   cpu_wdata, dma_wdata, mem_rdata;
  logic          cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [31:0]   cpu_rdata, dma_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   cpu_gnt_count, dma_gnt_count, conflict_count;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .cpu_gnt_count(cpu_gnt_count), .dma_gnt_count(dma_gnt_count),
    .conflict_count(conflict_count)
  );

  int total = 0;
  int bad   = 0;

  // Stimulus bumps this when it preloads the CPU counter; the compare
  // process notices the change and loads the same value into the model.
  int force_seq = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
  endtask

  task automatic cpu_rd(input logic [AW-1:0] a);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a; cpu_wdata = '0;
  endtask

  task automatic dma_rd(input logic [AW-1:0] a);
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = a; dma_wdata = '0;
  endtask

  // --------------------------------------------------------------------------
  // Reference model and per-cycle compare
  // --------------------------------------------------------------------------
  initial begin : compare
    int              losses;      // consecutive conflict cycles DMA has lost
    int              rd_owner;    // 0 none, 1 cpu, 2 dma: read issued last cycle
    longint unsigned n_cpu, n_dma, n_cfl;
    int              force_seen;
    bit              gc, gd;
    logic [AW-1:0]   e_addr;
    logic [31:0]     e_wdata;
    bit              e_we;
    losses = 0; rd_owner = 0; n_cpu = 0; n_dma = 0; n_cfl = 0; force_seen = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      #2;
      if (force_seq != force_seen) begin
        force_seen = force_seq;
        n_cpu = 64'hFFFF_FFFE;
      end

      gc = reset && cpu_req && !(dma_req && losses >= MAX_WAIT);
      gd = reset && dma_req && !gc;
      e_we = 1'b0; e_addr = '0; e_wdata = '0;
      if (gc) begin
        e_we = cpu_we; e_addr = cpu_addr; e_wdata = cpu_wdata;
      end else if (gd) begin
        e_we = dma_we; e_addr = dma_addr; e_wdata = dma_wdata;
      end

      chk("cpu_gnt",    cpu_gnt,    gc);
      chk("dma_gnt",    dma_gnt,    gd);
      chk("mem_en",     mem_en,     gc || gd);
      chk("mem_we",     mem_we,     e_we);
      chk("mem_addr",   mem_addr,   e_addr);
      chk("mem_wdata",  mem_wdata,  e_wdata);
      chk("cpu_rvalid", cpu_rvalid, reset && rd_owner == 1);
      chk("dma_rvalid", dma_rvalid, reset && rd_owner == 2);
      chk("cpu_rdata",  cpu_rdata,  (reset && rd_owner == 1) ? mem_rdata : 32'd0);
      chk("dma_rdata",  dma_rdata,  (reset && rd_owner == 2) ? mem_rdata : 32'd0);
      chk("cpu_cnt",    cpu_gnt_count,  n_cpu);
      chk("dma_cnt",    dma_gnt_count,  n_dma);
      chk("cfl_cnt",    conflict_count, n_cfl);

      // advance the model across the coming rising edge
      if (!reset) begin
        losses = 0; rd_owner = 0; n_cpu = 0; n_dma = 0; n_cfl = 0;
      end else begin
        if (gd)           losses = 0;
        else if (dma_req) losses = (losses + 1 > MAX_WAIT) ? MAX_WAIT : losses + 1;
        rd_owner = (gc && !cpu_we) ? 1 : (gd && !dma_we) ? 2 : 0;
        if (gc && n_cpu < 64'hFFFF_FFFF)                n_cpu++;
        if (gd && n_dma < 64'hFFFF_FFFF)                n_dma++;
        if (cpu_req && dma_req && n_cfl < 64'hFFFF_FFFF) n_cfl++;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus with literal spot checks
  // --------------------------------------------------------------------------
  initial begin : stim
    logic [9:0] pat;
    reset = 1'b0;
    idle();
    mem_rdata = '0;
    repeat (3) @(negedge clk);

    // CPU-only read of 0x10
    reset = 1'b1; cpu_rd(32'h10);
    #3 chk("lit_cpu_rd_gnt", cpu_gnt, 1'b1);
    @(negedge clk); idle(); mem_rdata = 32'h0000_00AB;
    #3;
    chk("lit_cpu_rd_rvalid", cpu_rvalid, 1'b1);
    chk("lit_cpu_rd_rdata",  cpu_rdata,  32'hAB);
    chk("lit_cpu_rd_dmarv",  dma_rvalid, 1'b0);
    chk("lit_cpu_rd_count",  cpu_gnt_count, 32'd1);

    // DMA write while CPU idle
    @(negedge clk); dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h20; dma_wdata = 32'hDEAD_BEEF;
    #3;
    chk("lit_dma_wr_en",    mem_en,    1'b1);
    chk("lit_dma_wr_we",    mem_we,    1'b1);
    chk("lit_dma_wr_addr",  mem_addr,  32'h20);
    chk("lit_dma_wr_wdata", mem_wdata, 32'hDEAD_BEEF);
    @(negedge clk); idle();
    #3;
    chk("lit_dma_wr_norv", {cpu_rvalid, dma_rvalid}, 2'b00);
    chk("lit_dma_wr_wait", dut.dma_wait_q, 0);

    // Alternating back-to-back reads
    @(negedge clk); cpu_rd(32'h4);
    @(negedge clk); idle(); dma_rd(32'h8); mem_rdata = 32'h1111_0004;
    #3 chk("lit_alt1", {cpu_rvalid, dma_rvalid, cpu_rdata}, {2'b10, 32'h1111_0004});
    @(negedge clk); idle(); cpu_rd(32'hC); mem_rdata = 32'h2222_0008;
    #3 chk("lit_alt2", {cpu_rvalid, dma_rvalid, dma_rdata}, {2'b01, 32'h2222_0008});
    @(negedge clk); idle(); mem_rdata = 32'h3333_000C;
    #3 chk("lit_alt3", {cpu_rvalid, dma_rvalid, cpu_rdata}, {2'b10, 32'h3333_000C});

    // Continuous conflict from a clean reset
    @(negedge clk); reset = 1'b0; idle();
    @(negedge clk); reset = 1'b1;
    pat = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); cpu_rd(32'h100); dma_rd(32'h200);
      #3 pat[i] = dma_gnt;
    end
    @(negedge clk); idle();
    #3;
    chk("lit_conflict_pattern", pat, 10'h210);
    chk("lit_conflict_count",   conflict_count, 32'd10);
    chk("lit_conflict_cpu_cnt", cpu_gnt_count,  32'd8);
    chk("lit_conflict_dma_cnt", dma_gnt_count,  32'd2);

    // Reset right after a granted CPU read
    @(negedge clk); cpu_rd(32'h40);
    @(negedge clk); reset = 1'b0; cpu_rd(32'h44); dma_rd(32'h48); mem_rdata = 32'h5555_AAAA;
    #3 chk("lit_rst_outputs", {cpu_rvalid, dma_rvalid, cpu_gnt, dma_gnt, mem_en, mem_we}, 6'b0);
    @(negedge clk);
    #3 chk("lit_rst_counts", {cpu_gnt_count, dma_gnt_count, conflict_count}, 96'd0);
    @(negedge clk); reset = 1'b1; idle();
    #3 chk("lit_rst_after_rv", {cpu_rvalid, dma_rvalid}, 2'b00);

    // Counter saturation via preload
    @(negedge clk); idle();
    force dut.cpu_cnt_q = 32'hFFFF_FFFE;
    force_seq++;
    #1 release dut.cpu_cnt_q;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); cpu_rd(32'h80);
    end
    @(negedge clk); idle();
    #3 chk("lit_sat_cpu_cnt", cpu_gnt_count, 32'hFFFF_FFFF);
    @(negedge clk); idle();
    #3 chk("lit_sat_cpu_hold", cpu_gnt_count, 32'hFFFF_FFFF);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      reset     = ($urandom_range(0, 79) != 0);
      cpu_req   = ($urandom_range(0, 3) != 0);
      cpu_we    = $urandom_range(0, 1);
      cpu_addr  = $urandom;
      cpu_wdata = $urandom;
      dma_req   = ($urandom_range(0, 4) < 3);
      dma_we    = $urandom_range(0, 1);
      dma_addr  = $urandom;
      dma_wdata = $urandom;
      mem_rdata = $urandom;
    end

    @(negedge clk); reset = 1'b1; idle();
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 4, meaning the number of consecutive cycles DMA may lose to the CPU before DMA is forced to win.
REQ-002 SHALL have parameter AW, default 32, meaning the address width; data width is fixed at 32.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 cpu_req / cpu_we  in  1 / 1  CPU access request; write when cpu_we=1.
REQ-006 cpu_addr / cpu_wdata  in  AW / 32  CPU address and write data.
REQ-007 cpu_gnt  out  1  CPU access accepted this cycle.
REQ-008 cpu_rvalid / cpu_rdata  out  1 / 32  CPU read data valid and data, one cycle after a granted read.
REQ-009 dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata  same directions and widths as the CPU port  DMA/host port.
REQ-010 mem_en / mem_we  out  1 / 1  memory access strobe and write enable.
REQ-011 mem_addr / mem_wdata  out  AW / 32  muxed address and write data to memory.
REQ-012 mem_rdata  in  32  memory read data, valid the cycle after mem_en=1 with mem_we=0.
REQ-013 cpu_gnt_count, dma_gnt_count, conflict_count  out  32 each  performance counters.

Function
REQ-014 Grant SHALL be combinational from the current-cycle requests and registered state; at most one of cpu_gnt and dma_gnt SHALL be 1 in any cycle.
REQ-015 A single requester SHALL be granted in the same cycle it requests.
REQ-016 On a conflict (both requests high), the CPU SHALL win unless dma_wait == MAX_WAIT, in which case the DMA SHALL win.
REQ-017 dma_wait SHALL increment, saturating at MAX_WAIT, on each cycle that dma_req=1 and dma_gnt=0. It SHALL clear to 0 on any DMA grant and SHALL hold when dma_req=0.
REQ-018 When any grant is given, mem_en SHALL be 1 and mem_we, mem_addr and mem_wdata SHALL equal the granted port's signals. With no grant, mem_en=0, mem_we=0 and address/data = 0.
REQ-019 A registered read-owner state (NONE, CPU, DMA) SHALL be set from the read grant of each cycle. In the following cycle, the owner's rvalid SHALL be 1 and its rdata SHALL equal mem_rdata; the other port's rvalid SHALL be 0 and its rdata SHALL be 0.
REQ-020 Granted writes SHALL produce no rvalid.
REQ-021 Back-to-back reads by alternating ports SHALL each return in order with one-cycle latency, with no bubble inserted.
REQ-022 cpu_gnt_count and dma_gnt_count SHALL increment by 1 per grant to the corresponding port.
REQ-023 conflict_count SHALL increment by 1 per cycle with both requests high.
REQ-024 All counters SHALL saturate at 0xFFFFFFFF rather than wrap.
REQ-025 Request signals SHALL not need to be held after a grant; an ungranted requester SHALL keep its request asserted until granted, and the arbiter SHALL not buffer requests.

Reset
REQ-026 While reset=0 at a rising edge, dma_wait, the read owner and all counters SHALL clear to 0/NONE.
REQ-027 While reset=0, all grants, mem_en, mem_we and both rvalid outputs SHALL be 0, regardless of the requests.
REQ-028 A read granted in the cycle before reset is asserted SHALL produce no rvalid in the reset cycle or the cycle after reset is deasserted.

Verification
REQ-029 CPU-only read of addr 0x10, memory returns 0x0000_00AB -> cpu_gnt=1 same cycle, cpu_rvalid=1 with cpu_rdata=0xAB next cycle, dma_rvalid=0, cpu_gnt_count=1.
REQ-030 Both request continuously, MAX_WAIT=4 -> CPU granted cycles 0-3, DMA granted cycle 4, CPU granted cycles 5-8, DMA granted cycle 9; conflict_count=10 after 10 cycles.
REQ-031 DMA write 0xDEAD_BEEF to 0x20 while CPU is idle -> mem_en=1, mem_we=1, mem_addr=0x20, mem_wdata=0xDEADBEEF, no rvalid, dma_wait stays 0.
REQ-032 Alternating reads CPU@0x4, DMA@0x8, CPU@0xC in consecutive cycles -> rvalid toggles CPU, DMA, CPU in the next three cycles with the matching mem_rdata.
REQ-033 Assert reset=0 in the cycle after a granted CPU read -> cpu_rvalid=0, all counters read 0 after the edge, and no grant while reset=0.
REQ-034 Preload cpu_gnt_count=0xFFFFFFFE via force, then issue 3 CPU grants -> the counter reads 0xFFFFFFFF and holds there.
